hsl_blob_tracker: RTL

HSL_BLOB_TRACKER -- requirements
Module: hsl_blob_tracker

---
 rtl/hsl_blob_tracker_pkg.sv | 30 +++
 rtl/hsl_blob_tracker_if.sv | 27 ++
 rtl/hsl_blob_tracker_serial_divider.sv | 56 +++++
 rtl/hsl_blob_tracker.sv | 139 +++++++++++++
 4 files changed

// File: rtl/hsl_blob_tracker_pkg.sv
// Shared widths, defaults, FSM encoding and small helpers for the HSL blob tracker.
package hsl_blob_tracker_pkg;
    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;
    localparam int CNT_W     = 19;
    localparam int SUM_W     = 28;
    localparam int X_W       = 10;
    localparam int Y_W       = 9;
    localparam int FX_W      = 18;
    localparam int HUE_W     = 9;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_DIVIDE, ST_HOLD} state_t;

    // 360 degrees is the same hue as 0; a window with lo > hi wraps through 0.
    function automatic logic hue_in(input logic [HUE_W-1:0] h, input logic [HUE_W-1:0] lo,
                                    input logic [HUE_W-1:0] hi);
        logic [HUE_W-1:0] hn;
        hn = (h == HUE_W'(360)) ? '0 : h;
        if (lo <= hi) return (hn >= lo) && (hn <= hi);
        return (hn >= lo) || (hn <= hi);
    endfunction

    function automatic logic [X_W-1:0] clip_x(input logic [SUM_W-1:0] q);
        return (|q[SUM_W-1:X_W]) ? '1 : q[X_W-1:0];
    endfunction

    function automatic logic [Y_W-1:0] clip_y(input logic [SUM_W-1:0] q);
        return (|q[SUM_W-1:Y_W]) ? '1 : q[Y_W-1:0];
    endfunction
endpackage

// File: rtl/hsl_blob_tracker_if.sv
// Pixel stream, thresholds, mask and frame-result bus of the blob tracker.
interface hsl_blob_tracker_if;
    import hsl_blob_tracker_pkg::*;
    logic             pix_valid, sof, eof;
    logic [X_W-1:0]   pix_x;
    logic [Y_W-1:0]   pix_y;
    logic [HUE_W-1:0] hue, hue_lo, hue_hi;
    logic [FX_W-1:0]  sat, lum, sat_min, lum_min, lum_max;
    logic             mask, mask_valid;
    logic             res_valid, res_ready, res_empty, overrun, frame_err;
    logic [CNT_W-1:0] res_count;
    logic [X_W-1:0]   res_cx, res_xmin, res_xmax;
    logic [Y_W-1:0]   res_cy, res_ymin, res_ymax;

    modport master (
        output pix_valid, sof, eof, pix_x, pix_y, hue, sat, lum,
               hue_lo, hue_hi, sat_min, lum_min, lum_max, res_ready,
        input  mask, mask_valid, res_valid, res_count, res_cx, res_cy,
               res_xmin, res_xmax, res_ymin, res_ymax, res_empty, overrun, frame_err
    );
    modport slave (
        input  pix_valid, sof, eof, pix_x, pix_y, hue, sat, lum,
               hue_lo, hue_hi, sat_min, lum_min, lum_max, res_ready,
        output mask, mask_valid, res_valid, res_count, res_cx, res_cy,
               res_xmin, res_xmax, res_ymin, res_ymax, res_empty, overrun, frame_err
    );
endinterface

// File: rtl/hsl_blob_tracker_serial_divider.sv
// Restoring serial divider: one quotient bit per cycle, DW cycles after start, done pulses once.
module serial_divider #(
    parameter int DW = 28,
    parameter int VW = 19
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          done,
    output logic [DW-1:0] quotient
);
    localparam int CW = $clog2(DW);

    logic [VW-1:0] rem;
    logic [DW-1:0] q;
    logic [CW-1:0] cnt;
    logic          busy;
    logic [VW:0]   trial;

    // q shifts dividend bits out of the top and quotient bits in at the bottom
    assign trial    = {rem, q[DW-1]};
    assign quotient = q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem  <= '0;
            q    <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                q    <= dividend;
                rem  <= '0;
                cnt  <= '0;
                busy <= 1'b1;
            end else if (busy) begin
                if (trial >= {1'b0, divisor}) begin
                    rem <= VW'(trial - {1'b0, divisor});
                    q   <= {q[DW-2:0], 1'b1};
                end else begin
                    rem <= trial[VW-1:0];
                    q   <= {q[DW-2:0], 1'b0};
                end
                cnt <= cnt + 1'b1;
                if (cnt == CW'(DW-1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/hsl_blob_tracker.sv
// Per-frame HSL window match: pixel mask, match count, centroid and bounding box.
module hsl_blob_tracker
    import hsl_blob_tracker_pkg::*;
#(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    hsl_blob_tracker_if.slave bus
);
    state_t st, nxt;
    logic [HUE_W-1:0] t_hlo, t_hhi, e_hlo, e_hhi;
    logic [FX_W-1:0]  t_smin, t_lmin, t_lmax, e_smin, e_lmin, e_lmax;
    logic             sof_v, match, hit;
    logic             acc_clr, acc_en, set_ovr, set_ferr, div_start, ld_res, ld_empty, div_run;
    logic [CNT_W-1:0] count, r_count;
    logic [SUM_W-1:0] sum_x, sum_y, qx, qy;
    logic [X_W-1:0]   xmin, xmax, r_cx, r_xmin, r_xmax;
    logic [Y_W-1:0]   ymin, ymax, r_cy, r_ymin, r_ymax;
    logic             done_x, done_y, mask_q, mvld_q, empty_q, ovr_q, ferr_q;

    assign sof_v = bus.pix_valid && bus.sof;

    // The sof pixel is judged by the port thresholds; the rest of the frame by the captured copy.
    assign e_hlo  = sof_v ? bus.hue_lo  : t_hlo;
    assign e_hhi  = sof_v ? bus.hue_hi  : t_hhi;
    assign e_smin = sof_v ? bus.sat_min : t_smin;
    assign e_lmin = sof_v ? bus.lum_min : t_lmin;
    assign e_lmax = sof_v ? bus.lum_max : t_lmax;

    assign match = hue_in(bus.hue, e_hlo, e_hhi) && (bus.sat >= e_smin) &&
                   (bus.lum >= e_lmin) && (bus.lum <= e_lmax);
    assign hit   = match && (32'(bus.pix_x) < H_RES) && (32'(bus.pix_y) < V_RES);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st <= ST_IDLE;
            {t_hlo, t_hhi, t_smin, t_lmin, t_lmax} <= '0;
            {mask_q, mvld_q, ovr_q, ferr_q, div_run} <= '0;
        end else begin
            st     <= nxt;
            mask_q <= bus.pix_valid && match;
            mvld_q <= bus.pix_valid;
            ovr_q  <= ovr_q | set_ovr;
            ferr_q <= ferr_q | set_ferr;
            if (sof_v) {t_hlo, t_hhi, t_smin, t_lmin, t_lmax} <= {e_hlo, e_hhi, e_smin, e_lmin, e_lmax};
            if (nxt != ST_DIVIDE) div_run <= 1'b0;
            else if (div_start)   div_run <= 1'b1;
        end
    end

    always_comb begin
        nxt = st; acc_clr = 1'b0; acc_en = 1'b0; set_ovr = 1'b0; set_ferr = 1'b0;
        div_start = 1'b0; ld_res = 1'b0; ld_empty = 1'b0;
        unique case (st)
            ST_IDLE: if (sof_v) begin
                acc_clr = 1'b1; acc_en = 1'b1;
                nxt = bus.eof ? ST_DIVIDE : ST_ACCUM;
            end
            ST_ACCUM: if (bus.pix_valid) begin
                acc_en = 1'b1;
                if (bus.sof) begin acc_clr = 1'b1; set_ferr = 1'b1; end
                if (bus.eof) nxt = ST_DIVIDE;
            end
            ST_DIVIDE: begin
                set_ovr = sof_v;
                if (!div_run) begin
                    if (count == '0) begin ld_empty = 1'b1; nxt = ST_HOLD; end
                    else div_start = 1'b1;
                end else if (done_x && done_y) begin
                    ld_res = 1'b1; nxt = ST_HOLD;
                end
            end
            ST_HOLD: if (bus.res_ready) begin
                nxt = ST_IDLE;
                if (sof_v) begin
                    acc_clr = 1'b1; acc_en = 1'b1;
                    nxt = bus.eof ? ST_DIVIDE : ST_ACCUM;
                end
            end else set_ovr = sof_v;
            default: nxt = ST_IDLE;
        endcase
    end

    // acc_clr with a hit restarts the frame from this pixel rather than from zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {count, sum_x, sum_y, xmax, ymax} <= '0;
            xmin <= '1; ymin <= '1;
        end else if (acc_en && hit) begin
            count <= (acc_clr ? '0 : count) + 1'b1;
            sum_x <= (acc_clr ? '0 : sum_x) + SUM_W'(bus.pix_x);
            sum_y <= (acc_clr ? '0 : sum_y) + SUM_W'(bus.pix_y);
            xmin  <= (acc_clr || bus.pix_x < xmin) ? bus.pix_x : xmin;
            xmax  <= (acc_clr || bus.pix_x > xmax) ? bus.pix_x : xmax;
            ymin  <= (acc_clr || bus.pix_y < ymin) ? bus.pix_y : ymin;
            ymax  <= (acc_clr || bus.pix_y > ymax) ? bus.pix_y : ymax;
        end else if (acc_clr) begin
            {count, sum_x, sum_y, xmax, ymax} <= '0;
            xmin <= '1; ymin <= '1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {r_count, r_cx, r_cy, r_xmin, r_xmax, r_ymin, r_ymax, empty_q} <= '0;
        end else if (ld_res) begin
            {r_count, r_cx, r_cy} <= {count, clip_x(qx), clip_y(qy)};
            {r_xmin, r_xmax, r_ymin, r_ymax, empty_q} <= {xmin, xmax, ymin, ymax, 1'b0};
        end else if (ld_empty) begin
            {r_count, r_cx, r_cy, r_xmin, r_xmax, r_ymin, r_ymax} <= '0;
            empty_q <= 1'b1;
        end
    end

    serial_divider #(.DW(SUM_W), .VW(CNT_W)) u_div_x (
        .clk(clk), .reset_n(reset_n), .start(div_start), .dividend(sum_x),
        .divisor(count), .done(done_x), .quotient(qx)
    );
    serial_divider #(.DW(SUM_W), .VW(CNT_W)) u_div_y (
        .clk(clk), .reset_n(reset_n), .start(div_start), .dividend(sum_y),
        .divisor(count), .done(done_y), .quotient(qy)
    );

    assign bus.mask       = mask_q;
    assign bus.mask_valid = mvld_q;
    assign bus.res_valid  = (st == ST_HOLD);
    assign bus.res_count  = r_count;
    assign bus.res_cx     = r_cx;
    assign bus.res_cy     = r_cy;
    assign bus.res_xmin   = r_xmin;
    assign bus.res_xmax   = r_xmax;
    assign bus.res_ymin   = r_ymin;
    assign bus.res_ymax   = r_ymax;
    assign bus.res_empty  = empty_q;
    assign bus.overrun    = ovr_q;
    assign bus.frame_err  = ferr_q;
endmodule
